pll_reset_sequencer: RTL

//   Sits directly downstream of the system PLL. Drives the PLL's active-high rst
//   and consumes its locked output. Releases staged, active-low resets to the
//   PLL-clocked logic only after lock has been continuously stable.
//   Re-arms the PLL on lock-acquisition timeout or on lock loss.

---
 rtl/pll_reset_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases staged active-low resets in order and re-arms on timeout or lock loss.
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT     = 50000,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned STAGE_GAP        = 256,
  parameter int unsigned LOSS_FILTER      = 4,
  parameter int unsigned NUM_STAGES       = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [7:0]            retry_count,
  input  logic                  clr_status
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CNT_MAX  = max2(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT),
                                          max2(STABLE_CYCLES, STAGE_GAP));
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned FILT_W   = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;

  localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [FILT_W-1:0] FILT_LAST    = FILT_W'(LOSS_FILTER - 1);
  localparam logic [NUM_STAGES-1:0] FIRST_STAGE = NUM_STAGES'(1);

  if (NUM_STAGES < 1 || NUM_STAGES > 4) begin : g_bad_stages
    $error("pll_reset_sequencer: NUM_STAGES must be in 1..4");
  end

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FILT_W-1:0]     filt_q, filt_d;
  logic                  sync1_q, locked_s_q;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_STAGES-1:0] rst_n_out_q, rst_n_out_d;
  logic                  ready_q, ready_d;
  logic                  lock_lost_q, lock_lost_d;
  logic [7:0]            retry_q, retry_d;
  logic                  loss_fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
    end
  end

  // Loss filter only counts while stages are (being) released; any good sample clears it.
  assign loss_fire = ((state_q == S_RELEASE) || (state_q == S_RUN)) &&
                     !locked_s_q && (filt_q == FILT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    filt_d      = '0;
    rst_n_out_d = rst_n_out_q;
    ready_d     = ready_q;
    lock_lost_d = lock_lost_q;
    retry_d     = retry_q;

    if (clr_status) begin
      lock_lost_d = 1'b0;
      retry_d     = '0;
    end

    case (state_q)
      S_PLL_RESET: begin
        rst_n_out_d = '0;
        ready_d     = 1'b0;
        if (cnt_q == PULSE_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      S_WAIT_LOCK: begin
        rst_n_out_d = '0;
        ready_d     = 1'b0;
        if (locked_s_q) begin
          // The sample that leaves WAIT_LOCK is the first of the stable run.
          state_d = S_STABLE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
          if (clr_status)          retry_d = 8'd1;
          else if (retry_q != '1)  retry_d = retry_q + 8'd1;
        end
      end

      S_STABLE: begin
        if (!locked_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d     = S_RELEASE;
          cnt_d       = '0;
          rst_n_out_d = FIRST_STAGE;
        end
      end

      S_RELEASE, S_RUN: begin
        if (!locked_s_q) filt_d = filt_q + FILT_W'(1);
        if (loss_fire) begin
          state_d     = S_PLL_RESET;
          cnt_d       = '0;
          filt_d      = '0;
          rst_n_out_d = '0;
          ready_d     = 1'b0;
          lock_lost_d = 1'b1;
        end else if (state_q == S_RUN) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (&rst_n_out_q) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            // Thermometer shift keeps release strictly low-to-high.
            rst_n_out_d = (rst_n_out_q << 1) | FIRST_STAGE;
          end
        end
      end

      default: begin
        state_d     = S_PLL_RESET;
        cnt_d       = '0;
        rst_n_out_d = '0;
        ready_d     = 1'b0;
      end
    endcase

    pll_rst_d = (state_d == S_PLL_RESET);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PLL_RESET;
      cnt_q       <= '0;
      filt_q      <= '0;
      pll_rst_q   <= 1'b1;
      rst_n_out_q <= '0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      pll_rst_q   <= pll_rst_d;
      rst_n_out_q <= rst_n_out_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
      retry_q     <= retry_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign rst_n_out   = rst_n_out_q;
  assign ready       = ready_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

endmodule
